laser_seq_ctrl: RTL and testbench

- Sequencer in front of the laser enable logic. Turns single-cycle operator requests into timed `modulate_on` / `cw_on` levels.
- Enforces an arm delay, a maximum on-time, a cool-down and a latched fault state on shutdown or analog-power loss.
- Its outputs drive the `modulate_on` / `cw_on` inputs of the laser interlock block.

---
 rtl/laser_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_laser_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_seq_ctrl.sv
// Laser sequencer: arm delay, bounded on-time, cool-down and latched fault state.
// Optional macro LASER_ACTIVE_CHECK_EN adds laser_active gating and interlock fault.
module laser_seq_ctrl #(
   parameter int CNT_W    = 24,
   parameter int ARM_DLY  = 1000,
   parameter int MAX_ON   = 1000000,
   parameter int COOL_DLY = 5000,
   parameter int DEB_LEN  = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req_modulate,
   input  logic       req_cw,
   input  logic       req_off,
   input  logic       fault_clear,
   input  logic       Analog_power_Good,
   input  logic       shutdown_n,
   input  logic       laser_active,
   output logic       modulate_on,
   output logic       cw_on,
   output logic [2:0] seq_state,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       pg_ok
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_ARM = 3'd1, S_MOD = 3'd2, S_CW = 3'd3, S_COOL = 3'd4, S_FAULT = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      FC_NONE = 3'd0, FC_SHUTDOWN = 3'd1, FC_POWER = 3'd2, FC_TIMEOUT = 3'd3, FC_INTERLOCK = 3'd4
   } fcode_t;

   localparam longint CNT_LIM = longint'(1) << CNT_W;
   localparam int DEB_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_DLY - 1);
   localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_ON - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_DLY - 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_LEN - 1);

   if (CNT_W < 1 || CNT_W > 62 || ARM_DLY < 1 || COOL_DLY < 1 || DEB_LEN < 1 || MAX_ON < 0 ||
       longint'(ARM_DLY) > CNT_LIM || longint'(MAX_ON) > CNT_LIM ||
       longint'(COOL_DLY) > CNT_LIM) begin : g_bad_cfg
      $error("laser_seq_ctrl: delay parameters out of range for CNT_W");
   end

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_cw_mode, w_cw_mode_nxt;
   logic [2:0]       r_fault_code, w_code_nxt;
   fcode_t           w_cause;
   logic             r_mod_on, r_cw_on, r_fault;
   logic             r_pg_ok;
   logic [DEB_W-1:0] r_deb_cnt;
   logic             w_on;
   logic             w_req_la_ok, w_la_lost;

`ifdef LASER_ACTIVE_CHECK_EN
   assign w_req_la_ok = laser_active;
   assign w_la_lost   = ~laser_active;
`else
   logic w_unused_la;
   assign w_unused_la = laser_active;
   assign w_req_la_ok = 1'b1;
   assign w_la_lost   = 1'b0;
`endif

   assign w_on = (r_state == S_MOD) || (r_state == S_CW);

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cw_mode_nxt = r_cw_mode;
      w_code_nxt    = r_fault_code;
      w_cause       = FC_NONE;

      if (r_state inside {S_ARM, S_MOD, S_CW, S_COOL}) begin
         if (!shutdown_n)                                            w_cause = FC_SHUTDOWN;
         else if (!r_pg_ok)                                          w_cause = FC_POWER;
         else if (w_on && w_la_lost)                                 w_cause = FC_INTERLOCK;
         else if (w_on && (MAX_ON != 0) && (r_cnt == MAX_LAST))      w_cause = FC_TIMEOUT;
      end

      if (w_cause != FC_NONE) begin
         w_state_nxt = S_FAULT;
         w_cnt_nxt   = '0;
         w_code_nxt  = w_cause;
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((req_modulate || req_cw) && r_pg_ok && shutdown_n && w_req_la_ok) begin
                  w_state_nxt   = S_ARM;
                  w_cnt_nxt     = '0;
                  w_cw_mode_nxt = ~req_modulate;
               end
            end
            S_ARM: begin
               if (req_off) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == ARM_LAST) begin
                  w_state_nxt = r_cw_mode ? S_CW : S_MOD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_MOD, S_CW: begin
               if (req_off) begin
                  w_state_nxt = S_COOL;
                  w_cnt_nxt   = '0;
               end else if (r_cnt != '1) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_COOL: begin
               if (r_cnt == COOL_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_FAULT: begin
               if (fault_clear && shutdown_n && r_pg_ok) begin
                  w_state_nxt = S_COOL;
                  w_cnt_nxt   = '0;
                  w_code_nxt  = FC_NONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_cw_mode    <= 1'b0;
         r_fault_code <= FC_NONE;
         r_mod_on     <= 1'b0;
         r_cw_on      <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cw_mode    <= w_cw_mode_nxt;
         r_fault_code <= w_code_nxt;
         r_mod_on     <= (w_state_nxt == S_MOD);
         r_cw_on      <= (w_state_nxt == S_CW);
         r_fault      <= (w_state_nxt == S_FAULT);
      end
   end

   // Debounce: pg_ok flips after DEB_LEN consecutive samples that disagree with it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_pg_ok   <= 1'b0;
         r_deb_cnt <= '0;
      end else if (Analog_power_Good != r_pg_ok) begin
         if (r_deb_cnt == DEB_LAST) begin
            r_pg_ok   <= Analog_power_Good;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
         end
      end else begin
         r_deb_cnt <= '0;
      end
   end

   assign modulate_on = r_mod_on;
   assign cw_on       = r_cw_on;
   assign seq_state   = r_state;
   assign fault       = r_fault;
   assign fault_code  = r_fault_code;
   assign pg_ok       = r_pg_ok;

endmodule

// File: tb/tb_laser_seq_ctrl.sv
// Bench for laser_seq_ctrl: directed vector table, reset corner sequence, then
// randomized stimulus against a timestamp-based reference model.
module tb_laser_seq_ctrl;

   localparam int ARM_DLY  = 8;
   localparam int MAX_ON   = 20;
   localparam int COOL_DLY = 4;
   localparam int DEB_LEN  = 3;
`ifdef LASER_ACTIVE_CHECK_EN
   localparam bit LA_EN = 1'b1;
`else
   localparam bit LA_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn, req_modulate, req_cw, req_off, fault_clear;
   logic       Analog_power_Good, shutdown_n, laser_active;
   logic       modulate_on, cw_on, fault, pg_ok;
   logic [2:0] seq_state, fault_code;

   always #5 clk = ~clk;

   laser_seq_ctrl #(
      .CNT_W(24), .ARM_DLY(ARM_DLY), .MAX_ON(MAX_ON), .COOL_DLY(COOL_DLY), .DEB_LEN(DEB_LEN)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_modulate(req_modulate), .req_cw(req_cw), .req_off(req_off), .fault_clear(fault_clear),
      .Analog_power_Good(Analog_power_Good), .shutdown_n(shutdown_n), .laser_active(laser_active),
      .modulate_on(modulate_on), .cw_on(cw_on), .seq_state(seq_state),
      .fault(fault), .fault_code(fault_code), .pg_ok(pg_ok)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b (state,mod,cw,fault,code,pg)", name, $time, act, exp);
      end
   endtask

   function automatic logic [8:0] dut_vec();
      return {seq_state, modulate_on, cw_on, fault, fault_code, pg_ok};
   endfunction

   function automatic logic [8:0] exp_vec(input int st, input int code, input bit pg);
      return {3'(st), st == 2, st == 3, st == 5, 3'(code), pg};
   endfunction

   // Reference model: tracks the state and the edge at which it was entered;
   // dwell time is edge count minus entry edge. Debounce is a sliding window.
   int m_state = 0, m_code = 0, m_enter = 0, cyc = 0;
   bit m_cw = 1'b0, m_pg = 1'b0;
   bit m_hist[$];
   int mv_dwell, mv_nxt, mv_cause;
   bit mv_flip;

   always @(posedge clk) begin
      cyc++;
      if (!rstn) begin
         m_state = 0; m_code = 0; m_pg = 1'b0; m_cw = 1'b0; m_enter = cyc;
         m_hist.delete();
      end else begin
         mv_dwell = cyc - m_enter;
         mv_nxt   = m_state;
         mv_cause = 0;
         if (m_state >= 1 && m_state <= 4) begin
            if (!shutdown_n) mv_cause = 1;
            else if (!m_pg) mv_cause = 2;
            else if (LA_EN && (m_state == 2 || m_state == 3) && !laser_active) mv_cause = 4;
            else if ((m_state == 2 || m_state == 3) && MAX_ON != 0 && mv_dwell == MAX_ON) mv_cause = 3;
         end
         if (mv_cause != 0) begin
            mv_nxt = 5; m_code = mv_cause;
         end else begin
            case (m_state)
               0: if ((req_modulate || req_cw) && m_pg && shutdown_n && (!LA_EN || laser_active)) begin
                     mv_nxt = 1; m_cw = !req_modulate;
                  end
               1: if (req_off) mv_nxt = 0;
                  else if (mv_dwell == ARM_DLY) mv_nxt = m_cw ? 3 : 2;
               2, 3: if (req_off) mv_nxt = 4;
               4: if (mv_dwell == COOL_DLY) mv_nxt = 0;
               5: if (fault_clear && shutdown_n && m_pg) begin mv_nxt = 4; m_code = 0; end
               default: mv_nxt = 0;
            endcase
         end
         if (mv_nxt != m_state) begin m_state = mv_nxt; m_enter = cyc; end
         m_hist.push_back(Analog_power_Good);
         if (m_hist.size() > DEB_LEN) void'(m_hist.pop_front());
         mv_flip = (m_hist.size() == DEB_LEN);
         foreach (m_hist[i]) if (m_hist[i] == m_pg) mv_flip = 1'b0;
         if (mv_flip) m_pg = !m_pg;
      end
   end

   always @(negedge clk) begin
      if (chk_en) check("model", dut_vec(), exp_vec(m_state, m_code, m_pg));
   end

   typedef struct {
      bit pg, sd, la, rm, rc, ro, fc;
      int n;
      logic [2:0] st, code;
      bit pgok;
   } vec_t;
   vec_t vt[$];

   function automatic void add(input bit pg, sd, la, rm, rc, ro, fc,
                               input int n, input int st, input int code, input bit pgok);
      vt.push_back('{pg, sd, la, rm, rc, ro, fc, n, 3'(st), 3'(code), pgok});
   endfunction

   task automatic step_pulse();
      @(negedge clk);
      req_modulate = 1'b0; req_cw = 1'b0; req_off = 1'b0; fault_clear = 1'b0;
   endtask

   bit pg_lvl;

   initial begin
      rstn = 1'b0; Analog_power_Good = 1'b1; shutdown_n = 1'b1; laser_active = 1'b1;
      req_modulate = 1'b0; req_cw = 1'b0; req_off = 1'b0; fault_clear = 1'b0;

      //  pg sd la rm rc ro fc   n  st code pgok
      add(1, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0);   // debounce still running
      add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1);   // pg_ok on third sample
      add(1, 1, 1, 1, 0, 0, 0,  1, 1, 0, 1);   // ARM
      add(1, 1, 1, 0, 0, 0, 0,  7, 1, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  1, 2, 0, 1);   // modulated output after ARM_DLY
      add(1, 1, 1, 0, 0, 0, 0,  5, 2, 0, 1);
      add(1, 1, 1, 0, 0, 1, 0,  1, 4, 0, 1);   // req_off -> COOL
      add(1, 1, 1, 0, 0, 0, 0,  3, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1);   // IDLE after COOL_DLY
      add(1, 1, 1, 0, 1, 0, 0,  1, 1, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  8, 3, 0, 1);   // CW
      add(1, 1, 1, 0, 0, 0, 0, 19, 3, 0, 1);   // still on at 20th cycle
      add(1, 1, 1, 0, 0, 0, 0,  1, 5, 3, 1);   // timeout fault
      add(1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  4, 0, 0, 1);
      add(1, 1, 1, 0, 1, 0, 0,  9, 3, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0,  2, 3, 0, 1);   // 2-cycle PG glitch absorbed
      add(1, 1, 1, 0, 0, 0, 0,  1, 3, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0,  3, 3, 0, 0);   // pg_ok drops
      add(0, 1, 1, 0, 0, 0, 0,  1, 5, 2, 0);   // power fault
      add(0, 1, 1, 0, 0, 0, 1,  1, 5, 2, 0);   // clear ignored, pg_ok low
      add(1, 1, 1, 0, 0, 0, 0,  3, 5, 2, 1);
      add(1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  4, 0, 0, 1);
      add(1, 1, 1, 1, 1, 0, 0,  9, 2, 0, 1);   // both requests -> modulated
      add(1, 0, 1, 0, 0, 1, 0,  1, 5, 1, 1);   // shutdown beats req_off
      add(1, 0, 1, 0, 0, 0, 1,  1, 5, 1, 1);   // clear ignored under shutdown
      add(1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  4, 0, 0, 1);
      add(1, 0, 1, 1, 0, 0, 0,  1, 0, 0, 1);   // request dropped under shutdown
      add(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
      add(1, 1, 1, 0, 1, 0, 0,  3, 1, 0, 1);
      add(1, 1, 1, 0, 0, 1, 0,  1, 0, 0, 1);   // req_off in ARM -> IDLE
      add(1, 1, 1, 1, 0, 0, 0,  2, 1, 0, 1);
      add(1, 0, 1, 0, 0, 0, 0,  1, 5, 1, 1);   // shutdown in ARM
      add(1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  4, 0, 0, 1);
      add(1, 1, 1, 1, 0, 0, 0,  9, 2, 0, 1);
      add(1, 1, 1, 0, 0, 1, 0,  1, 4, 0, 1);
      add(1, 1, 1, 0, 1, 0, 0,  4, 0, 0, 1);   // request in COOL ignored
`ifdef LASER_ACTIVE_CHECK_EN
      add(1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 1);   // request dropped, laser inactive
      add(1, 1, 1, 1, 0, 0, 0,  9, 2, 0, 1);
      add(1, 1, 0, 0, 0, 0, 0,  1, 5, 4, 1);   // interlock fault
      add(1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 1);
      add(1, 1, 1, 0, 0, 0, 0,  4, 0, 0, 1);
`else
      add(1, 1, 0, 1, 0, 0, 0,  9, 2, 0, 1);   // laser_active ignored
      add(1, 1, 0, 0, 0, 0, 0,  3, 2, 0, 1);
      add(1, 1, 1, 0, 0, 1, 0,  5, 0, 0, 1);
`endif

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_state", dut_vec(), exp_vec(0, 0, 0));
      rstn = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         Analog_power_Good = vt[i].pg; shutdown_n = vt[i].sd; laser_active = vt[i].la;
         req_modulate = vt[i].rm; req_cw = vt[i].rc; req_off = vt[i].ro; fault_clear = vt[i].fc;
         step_pulse();
         repeat (vt[i].n - 1) @(negedge clk);
         check($sformatf("vec%0d", i), dut_vec(), exp_vec(vt[i].st, vt[i].code, vt[i].pgok));
      end

      // Reset during modulated output, then requests in the first cycles after reset are dropped.
      Analog_power_Good = 1'b1; shutdown_n = 1'b1; laser_active = 1'b1;
      req_modulate = 1'b1;
      step_pulse();
      repeat (8) @(negedge clk);
      check("pre_reset_mod", dut_vec(), exp_vec(2, 0, 1));
      rstn = 1'b0;
      @(negedge clk);
      check("mid_reset", dut_vec(), exp_vec(0, 0, 0));
      rstn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         req_modulate = 1'b1;
         step_pulse();
         check($sformatf("post_reset_drop%0d", k), dut_vec(), exp_vec(0, 0, k == 3));
      end
      req_modulate = 1'b1;
      step_pulse();
      check("post_reset_accept", dut_vec(), exp_vec(1, 0, 1));
      req_off = 1'b1;
      step_pulse();
      check("post_reset_off", dut_vec(), exp_vec(0, 0, 1));

      // Randomized phase, checked against the model every cycle.
      pg_lvl = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         rstn = ($urandom_range(0, 399) != 0);
         if (pg_lvl ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0)) pg_lvl = !pg_lvl;
         Analog_power_Good = ($urandom_range(0, 9) == 0) ? !pg_lvl : pg_lvl;
         shutdown_n   = ($urandom_range(0, 99) != 0);
         laser_active = ($urandom_range(0, 59) != 0);
         req_modulate = ($urandom_range(0, 9) == 0);
         req_cw       = ($urandom_range(0, 9) == 0);
         req_off      = ($urandom_range(0, 39) == 0);
         fault_clear  = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      rstn = 1'b1;
      req_modulate = 1'b0; req_cw = 1'b0; req_off = 1'b0; fault_clear = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
